// File: rtl/uart_dbg_bridge.sv
// UART-to-OBI debug bridge: 0x11/0x12 + addr (+ wdata) in, one OBI access, ACK/NAK (+ rdata) out.
// Define UART_DBG_PARITY_EN for an even-parity bit on both RX and TX frames.
//
// state    | meaning
// IDLE     | waiting for a read (0x11) or write (0x12) command byte
// ADDR     | collecting 4 address bytes, LSB first
// DATA     | collecting 4 write-data bytes, LSB first
// BUS_REQ  | obi_req_o high until granted
// BUS_WAIT | waiting for obi_rvalid_i
// RESP     | sending ACK/NAK and read data, then draining the transmitter
module uart_dbg_bridge #(
  parameter int ClkFrequency = 20000000,
  parameter int UartBaudRate = 115200,
  parameter int TimeoutBits  = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i,
  output logic        busy_o
);

  localparam int ClksPerBit  = ClkFrequency / UartBaudRate;
  localparam int TimeoutClks = TimeoutBits * ClksPerBit;
  localparam int BitCntW     = $clog2(ClksPerBit);
  localparam int ToCntW      = $clog2(TimeoutClks);
`ifdef UART_DBG_PARITY_EN
  localparam int FrameBits   = 11;
`else
  localparam int FrameBits   = 10;
`endif

  localparam logic [BitCntW-1:0] BitLast  = BitCntW'(ClksPerBit - 1);
  localparam logic [BitCntW-1:0] HalfLast = BitCntW'(ClksPerBit / 2 - 1);
  localparam logic [ToCntW-1:0]  ToLast   = ToCntW'(TimeoutClks - 1);
  localparam logic [7:0]         CmdRead  = 8'h11;
  localparam logic [7:0]         CmdWrite = 8'h12;

  // ---------------- receiver ----------------
  logic               rx_meta, rx_sync;
  logic               rx_active, rx_valid, rx_ferr, rx_par_ok;
  logic [BitCntW-1:0] rx_cnt;
  logic [3:0]         rx_idx;
  logic [7:0]         rx_shift;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
    end
  end

`ifdef UART_DBG_PARITY_EN
  logic rx_par;
  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      rx_par <= 1'b0;
    else if (rx_active && rx_cnt == '0 && rx_idx == 4'd9)
      rx_par <= rx_sync;
  end
  assign rx_par_ok = ((^rx_shift) == rx_par);
`else
  assign rx_par_ok = 1'b1;
`endif

  // rx_idx: 0 start, 1..8 data, then optional parity, then stop
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_active) begin
        if (!rx_sync) begin
          rx_active <= 1'b1;
          rx_cnt    <= HalfLast;
          rx_idx    <= '0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= BitLast;
        rx_idx <= rx_idx + 1'b1;
        if (rx_idx == 4'd0) begin
          if (rx_sync) rx_active <= 1'b0;
        end else if (rx_idx <= 4'd8) begin
          rx_shift <= {rx_sync, rx_shift[7:1]};
        end else if (rx_idx == 4'(FrameBits - 1)) begin
          rx_active <= 1'b0;
          if (rx_sync && rx_par_ok) rx_valid <= 1'b1;
          else                      rx_ferr  <= 1'b1;
        end
      end
    end
  end

  // ---------------- transmitter ----------------
  logic                 tx_busy, tx_q, tx_start, tx_rdy;
  logic [7:0]           tx_byte;
  logic [FrameBits-2:0] tx_frame, tx_shift;
  logic [3:0]           tx_left;
  logic [BitCntW-1:0]   tx_cnt;

`ifdef UART_DBG_PARITY_EN
  assign tx_frame = {1'b1, ^tx_byte, tx_byte};
`else
  assign tx_frame = {1'b1, tx_byte};
`endif

  // Ready on the last cycle of a stop bit so back-to-back bytes have no gap.
  assign tx_rdy = !tx_busy || (tx_cnt == '0 && tx_left == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_busy  <= 1'b0;
      tx_q     <= 1'b1;
      tx_shift <= '1;
      tx_left  <= '0;
      tx_cnt   <= '0;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_q     <= 1'b0;
      tx_shift <= tx_frame;
      tx_left  <= 4'(FrameBits - 1);
      tx_cnt   <= BitLast;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_left != '0) begin
        tx_q     <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[FrameBits-2:1]};
        tx_left  <= tx_left - 1'b1;
        tx_cnt   <= BitLast;
      end else begin
        tx_busy <= 1'b0;
      end
    end
  end

  assign uart_tx_o = tx_q;

  // ---------------- command FSM ----------------
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP} state_e;

  state_e            state, state_n;
  logic [1:0]        byte_cnt;
  logic              is_write, rsp_err;
  logic [31:0]       addr_q, wdata_q, rdata_q;
  logic [2:0]        rsp_idx, rsp_num;
  logic [ToCntW-1:0] to_cnt;

  assign rsp_num = (rsp_err || is_write) ? 3'd1 : 3'd5;

  always_comb begin
    state_n  = state;
    tx_start = 1'b0;
    tx_byte  = rsp_err ? 8'h15 : 8'h06;
    unique case (state)
      IDLE: if (rx_valid && (rx_shift == CmdRead || rx_shift == CmdWrite)) state_n = ADDR;
      ADDR: begin
        if (rx_ferr)                            state_n = IDLE;
        else if (rx_valid && byte_cnt == 2'd3)  state_n = is_write ? DATA : BUS_REQ;
        else if (!rx_valid && to_cnt == '0)     state_n = IDLE;
      end
      DATA: begin
        if (rx_ferr)                            state_n = IDLE;
        else if (rx_valid && byte_cnt == 2'd3)  state_n = BUS_REQ;
        else if (!rx_valid && to_cnt == '0)     state_n = IDLE;
      end
      BUS_REQ:  if (obi_gnt_i)    state_n = BUS_WAIT;
      BUS_WAIT: if (obi_rvalid_i) state_n = RESP;
      RESP: begin
        if (rsp_idx != rsp_num) begin
          tx_start = tx_rdy;
          case (rsp_idx)
            3'd1:    tx_byte = rdata_q[7:0];
            3'd2:    tx_byte = rdata_q[15:8];
            3'd3:    tx_byte = rdata_q[23:16];
            3'd4:    tx_byte = rdata_q[31:24];
            default: tx_byte = rsp_err ? 8'h15 : 8'h06;
          endcase
        end else if (!tx_busy) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= IDLE;
      byte_cnt <= '0;
      is_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rsp_err  <= 1'b0;
      rsp_idx  <= '0;
      to_cnt   <= ToLast;
    end else begin
      state <= state_n;
      if (rx_valid || state == IDLE) to_cnt <= ToLast;
      else if (to_cnt != '0)         to_cnt <= to_cnt - 1'b1;
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (state_n == ADDR) is_write <= (rx_shift == CmdWrite);
        end
        ADDR: if (rx_valid) begin
          addr_q   <= {rx_shift, addr_q[31:8]};
          byte_cnt <= byte_cnt + 1'b1;
        end
        DATA: if (rx_valid) begin
          wdata_q  <= {rx_shift, wdata_q[31:8]};
          byte_cnt <= byte_cnt + 1'b1;
        end
        BUS_WAIT: if (obi_rvalid_i) begin
          rdata_q <= obi_rdata_i;
          rsp_err <= obi_err_i;
          rsp_idx <= '0;
        end
        RESP: if (tx_start) rsp_idx <= rsp_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign obi_req_o   = (state == BUS_REQ);
  assign obi_be_o    = obi_req_o ? 4'hF : 4'h0;
  assign obi_addr_o  = addr_q;
  assign obi_wdata_o = wdata_q;
  assign obi_we_o    = is_write;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Bench for uart_dbg_bridge: vector table, randomized commands against a transaction-level
// model, and hand-written timeout, framing-error and reset-during-response sequences.
module tb_uart_dbg_bridge;
  localparam int ClkFreq = 1_600_000;
  localparam int Baud    = 100_000;
  localparam int C       = ClkFreq / Baud;
`ifdef UART_DBG_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1, uart_tx;
  logic        obi_req, obi_gnt = 1'b0, obi_we, obi_rvalid = 1'b0, obi_err = 1'b0, busy;
  logic [31:0] obi_addr, obi_wdata, obi_rdata = '0;
  logic [3:0]  obi_be;

  uart_dbg_bridge #(.ClkFrequency(ClkFreq), .UartBaudRate(Baud), .TimeoutBits(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .uart_rx_i(uart_rx), .uart_tx_o(uart_tx),
    .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
    .obi_be_o(obi_be), .obi_wdata_o(obi_wdata), .obi_rvalid_i(obi_rvalid),
    .obi_rdata_i(obi_rdata), .obi_err_i(obi_err), .busy_o(busy));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; int hold; bit stable;
  } bus_rec_t;
  typedef struct {
    logic [7:0] op; logic [31:0] addr, wdata, rdata; logic err; int gd; logic [8:0] junk;
    logic exp_we; int exp_len; logic [39:0] exp_resp;
  } vec_t;

  bus_rec_t   bus_q[$];
  logic [7:0] tx_q[$];
  int         tx_edges = 0, tx_bad_frame = 0, tx_gap_bad = 0;
  int         gnt_delay = 0;
  logic [31:0] rsp_rdata = '0;
  logic        rsp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // OBI responder: grant after gnt_delay request cycles, rvalid the cycle after grant.
  initial begin : responder
    int hold; bit pending, stable; logic [31:0] a0, w0; logic we0;
    hold = 0; pending = 0; stable = 1; a0 = '0; w0 = '0; we0 = 0;
    forever begin
      @(negedge clk);
      obi_gnt = 0; obi_rvalid = 0; obi_err = 0;
      if (!rst_n) begin
        hold = 0; pending = 0;
      end else if (obi_req) begin
        if (hold == 0) begin a0 = obi_addr; w0 = obi_wdata; we0 = obi_we; stable = 1; end
        if (obi_addr !== a0 || obi_wdata !== w0 || obi_we !== we0 || obi_be !== 4'hF) stable = 0;
        if (hold >= gnt_delay) begin
          obi_gnt = 1;
          bus_q.push_back('{addr: obi_addr, we: obi_we, be: obi_be, wdata: obi_wdata,
                            hold: hold, stable: stable});
          hold = 0; pending = 1;
        end else hold++;
      end else if (pending) begin
        obi_rvalid = 1; obi_rdata = rsp_rdata; obi_err = rsp_err; pending = 0;
      end
    end
  end

  initial begin : edge_mon
    logic last;
    last = 1'b1;
    forever begin
      @(negedge clk);
      if (uart_tx !== last) tx_edges++;
      last = uart_tx;
    end
  end

  initial begin : tx_mon
    logic prev; logic [7:0] b; time t_last;
    prev = 1'b1; b = '0; t_last = 0;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && uart_tx === 1'b0) begin
        if (t_last != 0 && ($time - t_last) < 2 * FB * C * 10 && ($time - t_last) != FB * C * 10)
          tx_gap_bad++;
        t_last = $time;
        repeat (C / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin repeat (C) @(negedge clk); b[i] = uart_tx; end
`ifdef UART_DBG_PARITY_EN
        repeat (C) @(negedge clk);
        if (uart_tx !== ^b) tx_bad_frame++;
`endif
        repeat (C) @(negedge clk);
        if (uart_tx !== 1'b1) tx_bad_frame++;
        tx_q.push_back(b);
      end
      prev = uart_tx;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    logic [11:0] bits;
`ifdef UART_DBG_PARITY_EN
    bits = {1'b1, stop, ^b, b, 1'b0};
`else
    bits = {2'b11, stop, b, 1'b0};
`endif
    for (int i = 0; i < FB; i++) begin uart_rx = bits[i]; repeat (C) @(negedge clk); end
    uart_rx = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (op == 8'h12) for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin @(negedge clk); n++; end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Transaction-level reference: what the host should see for one command.
  function automatic void model_resp(input logic we, input logic err, input logic [31:0] rdata,
                                     output bq_t q);
    q = {};
    if (err) q.push_back(8'h15);
    else begin
      q.push_back(8'h06);
      if (!we) for (int i = 0; i < 4; i++) q.push_back(8'((rdata >> (8 * i)) & 32'hFF));
    end
  endfunction

  task automatic run_txn(input string name, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                         input int gd, input logic [8:0] junk, input logic exp_we, input bq_t exp);
    bus_rec_t r;
    gnt_delay = gd; rsp_rdata = rdata; rsp_err = err;
    bus_q.delete(); tx_q.delete();
    if (junk[8]) send_byte(junk[7:0]);
    send_cmd(op, addr, wdata);
    wait_idle(name, 20000);
    repeat (4) @(negedge clk);
    check({name, "_nbus"}, 32'(bus_q.size()), 32'd1);
    if (bus_q.size() > 0) begin
      r = bus_q[0];
      check({name, "_addr"}, r.addr, addr);
      check({name, "_we"}, 32'(r.we), 32'(exp_we));
      check({name, "_be"}, 32'(r.be), 32'hF);
      if (exp_we) check({name, "_wdata"}, r.wdata, wdata);
      check({name, "_hold"}, 32'(r.hold), 32'(gd));
      check({name, "_stable"}, 32'(r.stable), 32'd1);
    end
    check({name, "_ntx"}, 32'(tx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx%0d", name, i), 32'(tx_q[i]), 32'(exp[i]));
  endtask

  initial begin : main
    vec_t vecs[6];
    bq_t  exp;
    int   n, e0;
    logic [7:0] op, jb;
    logic [31:0] a, w, rd;
    logic er, jp;

    vecs[0] = '{op: 8'h12, addr: 32'h1000_0000, wdata: 32'hDEAD_BEEF, rdata: 32'h0, err: 0, gd: 0,
                junk: 9'h000, exp_we: 1, exp_len: 1, exp_resp: 40'h06};
    vecs[1] = '{op: 8'h11, addr: 32'h1000_0000, wdata: 32'h0, rdata: 32'hDEAD_BEEF, err: 0, gd: 0,
                junk: 9'h000, exp_we: 0, exp_len: 5, exp_resp: 40'hDE_AD_BE_EF_06};
    vecs[2] = '{op: 8'h11, addr: 32'h0000_0040, wdata: 32'h0, rdata: 32'h1234_5678, err: 1, gd: 1,
                junk: 9'h000, exp_we: 0, exp_len: 1, exp_resp: 40'h15};
    vecs[3] = '{op: 8'h11, addr: 32'h0000_0004, wdata: 32'h0, rdata: 32'hA5A5_5A5A, err: 0, gd: 20,
                junk: 9'h000, exp_we: 0, exp_len: 5, exp_resp: 40'hA5_A5_5A_5A_06};
    vecs[4] = '{op: 8'h12, addr: 32'hFFFF_FFFC, wdata: 32'h0102_0304, rdata: 32'h0, err: 1, gd: 3,
                junk: 9'h000, exp_we: 1, exp_len: 1, exp_resp: 40'h15};
    vecs[5] = '{op: 8'h11, addr: 32'h8000_0001, wdata: 32'h0, rdata: 32'h0000_0000, err: 0, gd: 0,
                junk: 9'h113, exp_we: 0, exp_len: 5, exp_resp: 40'h00_00_00_00_06};

    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_req", 32'(obi_req), 32'd0);
    check("rst_we", 32'(obi_we), 32'd0);
    check("rst_addr", obi_addr, 32'd0);
    check("rst_wdata", obi_wdata, 32'd0);
    check("rst_be", 32'(obi_be), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      exp = {};
      for (int i = 0; i < vecs[v].exp_len; i++) exp.push_back(vecs[v].exp_resp[8*i +: 8]);
      run_txn($sformatf("vec%0d", v), vecs[v].op, vecs[v].addr, vecs[v].wdata, vecs[v].rdata,
              vecs[v].err, vecs[v].gd, vecs[v].junk, vecs[v].exp_we, exp);
    end

    // Inter-byte timeout: partial write must abort silently, not early.
    bus_q.delete(); tx_q.delete(); gnt_delay = 0;
    send_byte(8'h12); send_byte(8'h00); send_byte(8'h00);
    repeat (900) @(negedge clk);
    check("to_busy_before", 32'(busy), 32'd1);
    repeat (250) @(negedge clk);
    check("to_busy_after", 32'(busy), 32'd0);
    check("to_nbus", 32'(bus_q.size()), 32'd0);
    check("to_ntx", 32'(tx_q.size()), 32'd0);
    model_resp(1'b0, 1'b0, 32'hCAFE_F00D, exp);
    run_txn("to_recover", 8'h11, 32'h1000_0000, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 9'h000, 1'b0, exp);

    // Framing errors: bad stop on the command byte, then on an address byte.
    bus_q.delete(); tx_q.delete();
    send_byte(8'h11, 1'b0);
    repeat (12 * C) @(negedge clk);
    send_cmd(8'h00, 32'h1000_0000, 32'h0);
    repeat (4 * C) @(negedge clk);
    check("fe_cmd_busy", 32'(busy), 32'd0);
    send_byte(8'h12); send_byte(8'h00); send_byte(8'h30, 1'b0);
    repeat (3 * C) @(negedge clk);
    check("fe_addr_busy", 32'(busy), 32'd0);
    repeat (12 * C) @(negedge clk);
    check("fe_nbus", 32'(bus_q.size()), 32'd0);
    check("fe_ntx", 32'(tx_q.size()), 32'd0);

    for (int k = 0; k < 10; k++) begin
      op = ($urandom_range(0, 1) == 1) ? 8'h12 : 8'h11;
      a = $urandom; w = $urandom; rd = $urandom;
      er = ($urandom_range(0, 3) == 0);
      jp = ($urandom_range(0, 1) == 1);
      do jb = 8'($urandom_range(0, 255)); while (jb == 8'h11 || jb == 8'h12);
      model_resp(op == 8'h12, er, rd, exp);
      run_txn($sformatf("rnd%0d", k), op, a, w, rd, er, $urandom_range(0, 5), {jp, jb},
              op == 8'h12, exp);
    end

    // Reset during the second data bit of the ACK.
    gnt_delay = 0; rsp_rdata = 32'h0F0F_0F0F; rsp_err = 1'b0;
    send_cmd(8'h11, 32'h2000_0000, 32'h0);
    n = 0;
    while (uart_tx === 1'b1 && n < 5000) begin @(negedge clk); n++; end
    check("rst_mid_start_seen", 32'(uart_tx), 32'd0);
    repeat (2 * C + C / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", 32'(uart_tx), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_req", 32'(obi_req), 32'd0);
    rst_n = 1'b1;
    e0 = tx_edges;
    repeat (6 * FB * C) @(negedge clk);
    check("rst_mid_no_edges", 32'(tx_edges - e0), 32'd0);
    check("rst_mid_busy_after", 32'(busy), 32'd0);
    tx_q.delete(); bus_q.delete();
    model_resp(1'b1, 1'b0, 32'h0, exp);
    run_txn("rst_recover", 8'h12, 32'h0000_0100, 32'h5555_AAAA, 32'h0, 1'b0, 2, 9'h000, 1'b1, exp);

    check("tx_frames_ok", 32'(tx_bad_frame), 32'd0);
    check("tx_no_gap", 32'(tx_gap_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
